ascon_ctrl: RTL and testbench



---
 rtl/ascon_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_ascon_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ctrl.sv
// Ascon AEAD control FSM: sequences the init, AD, message and finalisation permutations for encrypt or decrypt.
// Latency: LOAD..FIN_END = (PA+2) + A*(PB+2) + (M-1)*(PB+2) + (PA+2) cycles, plus WAIT stalls; DONE follows.
// Backpressure: holds in *_WAIT states until data_valid_i; abort_i returns to IDLE from any busy state.
module ascon_ctrl #(
    parameter int PA_ROUNDS = 12,  // legal 1..12
    parameter int PB_ROUNDS = 6,   // legal 1..PA_ROUNDS
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [CNT_W-1:0] ad_blocks_i,
    input  logic [CNT_W-1:0] msg_blocks_i,
    input  logic             abort_i,
    input  logic             data_valid_i,
    input  logic             tag_ok_i,
    output logic             data_req_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             load_state_o,
    output logic [3:0]       rnd_idx_o,
    output logic             sel_state_init_o,
    output logic             sel_xor_init_o,
    output logic             sel_xor_ext_o,
    output logic             sel_xor_dom_sep_o,
    output logic             sel_xor_fin_o,
    output logic             sel_xor_tag_o,
    output logic             sel_ct_replace_o,
    output logic             ct_valid_o,
    output logic             tag_valid_o,
    output logic             auth_ok_o,
    output logic             auth_fail_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_INIT, S_INIT_END,
        S_AD_WAIT, S_AD_PERM, S_AD_END,
        S_MSG_WAIT, S_MSG_PERM, S_MSG_END,
        S_FIN_WAIT, S_FIN_PERM, S_FIN_END, S_DONE
    } state_e;

    localparam logic [3:0] PA_L = 4'(PA_ROUNDS);
    localparam logic [3:0] PB_L = 4'(PB_ROUNDS);

    state_e           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;       // rounds remaining in the current permutation
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic             dec_q, dec_d;
    logic             auth_ok_q, auth_ok_d;
    logic             auth_fail_q, auth_fail_d;

    // The round counter starts at N, so it equals N only in the first round.
    logic first_pa, first_pb;
    assign first_pa = (rnd_q == PA_L);
    assign first_pb = (rnd_q == PB_L);

    // After init or an AD block: more AD, else the last (final) message block, else message blocks.
    function automatic state_e route_after_ad(input logic [CNT_W-1:0] ad, input logic [CNT_W-1:0] msg);
        if (ad != '0)
            return S_AD_WAIT;
        else if (msg == CNT_W'(1))
            return S_FIN_WAIT;
        else
            return S_MSG_WAIT;
    endfunction

    // State, counter and verdict registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rnd_q       <= '0;
            ad_cnt_q    <= '0;
            msg_cnt_q   <= '0;
            dec_q       <= 1'b0;
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            ad_cnt_q    <= ad_cnt_d;
            msg_cnt_q   <= msg_cnt_d;
            dec_q       <= dec_d;
            auth_ok_q   <= auth_ok_d;
            auth_fail_q <= auth_fail_d;
        end
    end

    // Next-state and counter update; abort overrides everything while busy.
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        ad_cnt_d    = ad_cnt_q;
        msg_cnt_d   = msg_cnt_q;
        dec_d       = dec_q;
        auth_ok_d   = auth_ok_q;
        auth_fail_d = auth_fail_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_LOAD;
                    dec_d       = decrypt_i;
                    ad_cnt_d    = ad_blocks_i;
                    msg_cnt_d   = (msg_blocks_i == '0) ? CNT_W'(1) : msg_blocks_i;
                    auth_ok_d   = 1'b0;
                    auth_fail_d = 1'b0;
                end
            end
            S_LOAD: begin
                rnd_d   = PA_L;
                state_d = S_INIT;
            end
            S_INIT: begin
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = S_INIT_END;
            end
            S_INIT_END, S_AD_END: state_d = route_after_ad(ad_cnt_q, msg_cnt_q);
            S_AD_WAIT: begin
                rnd_d = PB_L;
                if (data_valid_i) state_d = S_AD_PERM;
            end
            S_AD_PERM: begin
                if (first_pb && (ad_cnt_q != '0)) ad_cnt_d = ad_cnt_q - CNT_W'(1);
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = S_AD_END;
            end
            S_MSG_WAIT: begin
                rnd_d = PB_L;
                if (data_valid_i) state_d = S_MSG_PERM;
            end
            S_MSG_PERM: begin
                if (first_pb && (msg_cnt_q != '0)) msg_cnt_d = msg_cnt_q - CNT_W'(1);
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = S_MSG_END;
            end
            S_MSG_END: state_d = (msg_cnt_q == CNT_W'(1)) ? S_FIN_WAIT : S_MSG_WAIT;
            S_FIN_WAIT: begin
                rnd_d = PA_L;
                if (data_valid_i) state_d = S_FIN_PERM;
            end
            S_FIN_PERM: begin
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = S_FIN_END;
            end
            S_FIN_END: begin
                if (dec_q) begin
                    auth_ok_d   = tag_ok_i;
                    auth_fail_d = !tag_ok_i;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d     = S_IDLE;
            auth_ok_d   = 1'b0;
            auth_fail_d = 1'b0;
        end
    end

    // Moore output decode from state, round counter and block counters.
    always_comb begin
        data_req_o        = 1'b0;
        ready_o           = 1'b0;
        done_o            = 1'b0;
        load_state_o      = 1'b0;
        rnd_idx_o         = 4'd0;
        sel_state_init_o  = 1'b0;
        sel_xor_init_o    = 1'b0;
        sel_xor_ext_o     = 1'b0;
        sel_xor_dom_sep_o = 1'b0;
        sel_xor_fin_o     = 1'b0;
        sel_xor_tag_o     = 1'b0;
        sel_ct_replace_o  = 1'b0;
        ct_valid_o        = 1'b0;
        tag_valid_o       = 1'b0;
        case (state_q)
            S_IDLE: ready_o = 1'b1;
            S_DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
            end
            S_INIT: begin
                load_state_o     = 1'b1;
                rnd_idx_o        = 4'd12 - rnd_q;
                sel_state_init_o = first_pa;
            end
            S_INIT_END: begin
                load_state_o      = 1'b1;
                sel_xor_init_o    = 1'b1;
                data_req_o        = 1'b1;
                sel_xor_dom_sep_o = (ad_cnt_q == '0);
            end
            S_AD_PERM: begin
                load_state_o  = 1'b1;
                rnd_idx_o     = 4'd12 - rnd_q;
                sel_xor_ext_o = first_pb;
            end
            S_AD_END: begin
                load_state_o      = 1'b1;
                data_req_o        = 1'b1;
                sel_xor_dom_sep_o = (ad_cnt_q == '0);
            end
            S_MSG_PERM: begin
                load_state_o     = 1'b1;
                rnd_idx_o        = 4'd12 - rnd_q;
                sel_xor_ext_o    = first_pb;
                ct_valid_o       = first_pb;
                sel_ct_replace_o = first_pb && dec_q;
            end
            S_MSG_END: begin
                load_state_o = 1'b1;
                data_req_o   = 1'b1;
            end
            S_FIN_PERM: begin
                load_state_o     = 1'b1;
                rnd_idx_o        = 4'd12 - rnd_q;
                sel_xor_ext_o    = first_pa;
                sel_xor_fin_o    = first_pa;
                ct_valid_o       = first_pa;
                sel_ct_replace_o = first_pa && dec_q;
            end
            S_FIN_END: begin
                load_state_o  = 1'b1;
                sel_xor_tag_o = 1'b1;
                tag_valid_o   = !dec_q;
            end
            default: ;
        endcase
        busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
        auth_ok_o   = auth_ok_q;
        auth_fail_o = auth_fail_q;
    end
endmodule

// File: tb/tb_ascon_ctrl.sv
// Bench for ascon_ctrl: a phase-list reference model predicts every output each cycle.
// Two instances: default depths (12/6) and hash-like depths (8/8), sharing stimulus.
// Inputs driven #1 after the rising edge, outputs sampled on the falling edge.
module tb_ascon_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, dec_in = 1'b0, abort = 1'b0, valid = 1'b0, tag_ok = 1'b0;
    logic [15:0] ad_in = '0, msg_in = '0;
    logic        use8 = 1'b0;
    // bits: 19 req, 18 ready, 17 busy, 16 done, 15 load, 14:11 rnd, 10 init, 9 xinit,
    //       8 ext, 7 dom, 6 fin, 5 xtag, 4 ctrep, 3 ct_valid, 2 tag_valid, 1 ok, 0 fail
    wire [19:0] o12, o8;

    ascon_ctrl #(.PA_ROUNDS(12), .PB_ROUNDS(6), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start & ~use8), .decrypt_i(dec_in),
        .ad_blocks_i(ad_in), .msg_blocks_i(msg_in), .abort_i(abort), .data_valid_i(valid),
        .tag_ok_i(tag_ok), .data_req_o(o12[19]), .ready_o(o12[18]), .busy_o(o12[17]),
        .done_o(o12[16]), .load_state_o(o12[15]), .rnd_idx_o(o12[14:11]),
        .sel_state_init_o(o12[10]), .sel_xor_init_o(o12[9]), .sel_xor_ext_o(o12[8]),
        .sel_xor_dom_sep_o(o12[7]), .sel_xor_fin_o(o12[6]), .sel_xor_tag_o(o12[5]),
        .sel_ct_replace_o(o12[4]), .ct_valid_o(o12[3]), .tag_valid_o(o12[2]),
        .auth_ok_o(o12[1]), .auth_fail_o(o12[0]));

    ascon_ctrl #(.PA_ROUNDS(8), .PB_ROUNDS(8), .CNT_W(16)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start & use8), .decrypt_i(dec_in),
        .ad_blocks_i(ad_in), .msg_blocks_i(msg_in), .abort_i(abort), .data_valid_i(valid),
        .tag_ok_i(tag_ok), .data_req_o(o8[19]), .ready_o(o8[18]), .busy_o(o8[17]),
        .done_o(o8[16]), .load_state_o(o8[15]), .rnd_idx_o(o8[14:11]),
        .sel_state_init_o(o8[10]), .sel_xor_init_o(o8[9]), .sel_xor_ext_o(o8[8]),
        .sel_xor_dom_sep_o(o8[7]), .sel_xor_fin_o(o8[6]), .sel_xor_tag_o(o8[5]),
        .sel_ct_replace_o(o8[4]), .ct_valid_o(o8[3]), .tag_valid_o(o8[2]),
        .auth_ok_o(o8[1]), .auth_fail_o(o8[0]));

    int vectors = 0, miscompares = 0;

    localparam int K_LOAD = 0, K_INIT = 1, K_INIT_END = 2, K_WAIT = 3, K_ADP = 4, K_AD_END = 5;
    localparam int K_MSGP = 6, K_MSG_END = 7, K_FINP = 8, K_FIN_END = 9;

    // Expected operation as a list of phases, each lasting a fixed number of cycles (WAIT: until valid).
    int ph_kind[$];
    int ph_len[$];
    bit ph_dom[$];

    // State each instance should be in before the next start: done flag and held verdict.
    bit pre_done[2], pre_ok[2], pre_fail[2];

    // First-occurrence cycles and pulse counts observed from the DUT in the latest operation.
    int fst_init, fst_xinit, fst_dom, fst_ct, fst_tag, fst_done;
    int n_req, n_ct, n_ctrep, n_dom, n_tagv;

    function automatic void push_ph(input int kind, input int len, input bit dom);
        ph_kind.push_back(kind);
        ph_len.push_back(len);
        ph_dom.push_back(dom);
    endfunction

    function automatic void build_phases(input int pa, input int pb, input int a, input int mm);
        ph_kind.delete();
        ph_len.delete();
        ph_dom.delete();
        push_ph(K_LOAD, 1, 0);
        push_ph(K_INIT, pa, 0);
        push_ph(K_INIT_END, 1, a == 0);
        for (int i = 0; i < a; i++) begin
            push_ph(K_WAIT, 1, 0);
            push_ph(K_ADP, pb, 0);
            push_ph(K_AD_END, 1, i == a - 1);
        end
        for (int j = 0; j < mm - 1; j++) begin
            push_ph(K_WAIT, 1, 0);
            push_ph(K_MSGP, pb, 0);
            push_ph(K_MSG_END, 1, 0);
        end
        push_ph(K_WAIT, 1, 0);
        push_ph(K_FINP, pa, 0);
        push_ph(K_FIN_END, 1, 0);
    endfunction

    function automatic logic [19:0] idle_vec(input bit done, input bit ok, input bit fail);
        logic [19:0] v = '0;
        v[18] = 1'b1;
        v[16] = done;
        v[1]  = ok;
        v[0]  = fail;
        return v;
    endfunction

    // Outputs for cycle k of a phase; round index follows 12 - N + k.
    function automatic logic [19:0] model_out(input int kind, input int k, input int len,
                                              input bit dom, input bit d);
        logic [19:0] v = '0;
        v[17] = 1'b1;
        case (kind)
            K_INIT: begin
                v[15] = 1'b1; v[14:11] = 4'(12 - len + k); v[10] = (k == 0);
            end
            K_INIT_END: begin
                v[19] = 1'b1; v[15] = 1'b1; v[9] = 1'b1; v[7] = dom;
            end
            K_ADP, K_MSGP, K_FINP: begin
                v[15] = 1'b1; v[14:11] = 4'(12 - len + k); v[8] = (k == 0);
                if (kind == K_FINP) v[6] = (k == 0);
                if (kind != K_ADP) begin
                    v[3] = (k == 0);
                    v[4] = (k == 0) && d;
                end
            end
            K_AD_END: begin
                v[19] = 1'b1; v[15] = 1'b1; v[7] = dom;
            end
            K_MSG_END: begin
                v[19] = 1'b1; v[15] = 1'b1;
            end
            K_FIN_END: begin
                v[15] = 1'b1; v[5] = 1'b1; v[2] = !d;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic note(input logic [19:0] o, input int c);
        if (o[10] && fst_init < 0) fst_init = c;
        if (o[9] && fst_xinit < 0) fst_xinit = c;
        if (o[7]) begin n_dom++; if (fst_dom < 0) fst_dom = c; end
        if (o[3]) begin n_ct++; if (fst_ct < 0) fst_ct = c; end
        if (o[4]) n_ctrep++;
        if (o[2]) begin n_tagv++; if (fst_tag < 0) fst_tag = c; end
        if (o[16] && fst_done < 0) fst_done = c;
        if (o[19]) n_req++;
    endtask

    // One operation on the chosen instance, checked every cycle; optional abort/reset cut and start glitch.
    task automatic run_op(input bit u8, input int pa, input int pb, input bit d, input int a,
                          input int m, input int stall_pct, input bit tok, input int cut,
                          input bit cut_rst, input int glitch);
        int mm, idx, k, cyc, st_here, st_total, lat;
        bit stop;
        logic [19:0] exp, obs;
        mm = (m == 0) ? 1 : m;
        build_phases(pa, pb, a, mm);
        idx = 0; k = 0; cyc = 1; st_here = 0; st_total = 0; stop = 1'b0;
        fst_init = -1; fst_xinit = -1; fst_dom = -1; fst_ct = -1; fst_tag = -1; fst_done = -1;
        n_req = 0; n_ct = 0; n_ctrep = 0; n_dom = 0; n_tagv = 0;
        @(negedge clk);
        use8 = u8;
        obs = u8 ? o8 : o12;
        exp = idle_vec(pre_done[u8], pre_ok[u8], pre_fail[u8]);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL pre_start got=%h exp=%h", obs, exp);
        end
        start = 1'b1; dec_in = d; ad_in = 16'(a); msg_in = 16'(m); tag_ok = tok;
        @(posedge clk); #1;
        start = 1'b0; dec_in = 1'($urandom_range(1)); ad_in = 16'($urandom); msg_in = 16'($urandom);
        while (idx < ph_kind.size() && !stop) begin
            @(negedge clk);
            obs = u8 ? o8 : o12;
            exp = model_out(ph_kind[idx], k, ph_len[idx], ph_dom[idx], d);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL run cyc=%0d phase=%0d k=%0d got=%h exp=%h", cyc, ph_kind[idx], k, obs, exp);
            end
            note(obs, cyc);
            if (ph_kind[idx] == K_WAIT)
                valid = (st_here >= 5) || ($urandom_range(99) >= stall_pct);
            else
                valid = 1'($urandom_range(1));
            if (cyc == glitch) begin
                start = 1'b1; dec_in = ~d; ad_in = 16'($urandom_range(5)); msg_in = 16'($urandom_range(5));
            end
            if (cyc == cut) begin
                if (cut_rst) rst = 1'b1;
                else begin abort = 1'b1; valid = 1'b1; end
            end
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (cyc == cut) stop = 1'b1;
            else if (ph_kind[idx] == K_WAIT) begin
                if (valid) begin idx++; st_here = 0; end
                else begin st_here++; st_total++; end
            end else if (k + 1 == ph_len[idx]) begin
                idx++; k = 0;
            end else k++;
            cyc++;
        end
        if (stop) begin
            @(negedge clk);
            obs = u8 ? o8 : o12;
            vectors++;
            if (obs !== idle_vec(0, 0, 0)) begin
                miscompares++;
                $display("FAIL after_cut got=%h exp=%h", obs, idle_vec(0, 0, 0));
            end
            pre_done[u8] = 0; pre_ok[u8] = 0; pre_fail[u8] = 0;
            if (cut_rst) begin pre_done[!u8] = 0; pre_ok[!u8] = 0; pre_fail[!u8] = 0; end
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                obs = u8 ? o8 : o12;
                note(obs, cyc);
                exp = idle_vec(1, d & tok, d & !tok);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL done_hold cyc=%0d got=%h exp=%h", cyc, obs, exp);
                end
                cyc++;
            end
            lat = (pa + 2) + a * (pb + 2) + (mm - 1) * (pb + 2) + (pa + 2) + st_total;
            vectors++;
            if (fst_done !== lat + 1) begin
                miscompares++;
                $display("FAIL latency got=%0d exp=%0d", fst_done, lat + 1);
            end
            vectors++;
            if (n_req !== a + mm) begin
                miscompares++;
                $display("FAIL req_count got=%0d exp=%0d", n_req, a + mm);
            end
            pre_done[u8] = 1; pre_ok[u8] = d & tok; pre_fail[u8] = d & !tok;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (o12 !== idle_vec(0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset12 got=%h exp=%h", o12, idle_vec(0, 0, 0));
            end
            vectors++;
            if (o8 !== idle_vec(0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset8 got=%h exp=%h", o8, idle_vec(0, 0, 0));
            end
        end
        pre_done = '{0, 0}; pre_ok = '{0, 0}; pre_fail = '{0, 0};
    endtask

    task automatic test_encrypt_basic();
        run_op(0, 12, 6, 0, 1, 1, 0, 0, -1, 0, -1);
        vectors++;
        if (fst_init !== 2) begin miscompares++; $display("FAIL enc_init_cycle got=%0d exp=2", fst_init); end
        vectors++;
        if (fst_xinit !== 14) begin miscompares++; $display("FAIL enc_init_end got=%0d exp=14", fst_xinit); end
        vectors++;
        if (fst_ct !== 24) begin miscompares++; $display("FAIL enc_ct_cycle got=%0d exp=24", fst_ct); end
        vectors++;
        if (fst_tag !== 36) begin miscompares++; $display("FAIL enc_tag_cycle got=%0d exp=36", fst_tag); end
        vectors++;
        if (fst_done !== 37) begin miscompares++; $display("FAIL enc_done_cycle got=%0d exp=37", fst_done); end
    endtask

    task automatic test_no_ad();
        run_op(0, 12, 6, 0, 0, 1, 0, 0, -1, 0, -1);
        vectors++;
        if (fst_xinit !== 14 || fst_dom !== 14) begin
            miscompares++;
            $display("FAIL noad_domsep got=%0d/%0d exp=14/14", fst_xinit, fst_dom);
        end
        vectors++;
        if (fst_tag !== 28) begin miscompares++; $display("FAIL noad_tag got=%0d exp=28", fst_tag); end
    endtask

    task automatic test_decrypt_fail();
        run_op(0, 12, 6, 1, 2, 3, 0, 0, -1, 0, -1);
        vectors++;
        if (n_ct !== 3 || n_ctrep !== 3) begin
            miscompares++;
            $display("FAIL dec_ct_counts got=%0d/%0d exp=3/3", n_ct, n_ctrep);
        end
        vectors++;
        if (n_dom !== 1 || n_tagv !== 0) begin
            miscompares++;
            $display("FAIL dec_dom_tag got=%0d/%0d exp=1/0", n_dom, n_tagv);
        end
        // abort is ignored in DONE: verdict stays held
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (o12 !== idle_vec(1, 0, 1)) begin
            miscompares++;
            $display("FAIL abort_in_done got=%h exp=%h", o12, idle_vec(1, 0, 1));
        end
    endtask

    task automatic test_back_to_back();
        run_op(0, 12, 6, 1, 1, 2, 30, 1, -1, 0, -1);
        run_op(0, 12, 6, 0, 1, 2, 30, 0, -1, 0, -1);
    endtask

    task automatic test_start_ignored();
        run_op(0, 12, 6, 0, 1, 2, 0, 0, -1, 0, 20);
    endtask

    task automatic test_abort();
        run_op(0, 12, 6, 0, 2, 2, 0, 0, 18, 0, -1);
        run_op(0, 12, 6, 0, 0, 0, 0, 0, -1, 0, -1);
        vectors++;
        if (fst_tag !== 28 || n_ct !== 1) begin
            miscompares++;
            $display("FAIL abort_restart got=%0d/%0d exp=28/1", fst_tag, n_ct);
        end
    endtask

    task automatic test_deep_reset();
        run_op(1, 8, 8, 0, 1, 2, 0, 0, 25, 1, -1);
        vectors++;
        if (o12 !== idle_vec(0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_other got=%h exp=%h", o12, idle_vec(0, 0, 0));
        end
        run_op(1, 8, 8, 1, 1, 2, 0, 1, -1, 0, -1);
    endtask

    task automatic test_random_stalls();
        for (int i = 0; i < 12; i++) begin
            bit u8;
            u8 = (i % 4 == 3);
            run_op(u8, u8 ? 8 : 12, u8 ? 8 : 6, 1'($urandom_range(1)), $urandom_range(3),
                   $urandom_range(4), 40, 1'($urandom_range(1)), -1, 0, -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encrypt_basic();
        test_no_ad();
        test_decrypt_fail();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_deep_reset();
        test_random_stalls();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
